// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Posted-store buffer between the pipeline MEM stage and the downstream
// cache/SRAM path. Stores are accepted into a small circular FIFO and written
// out in order. Loads that hit a buffered word are answered from the youngest
// matching entry in the same cycle. Loads that miss wait until the FIFO has
// drained, then issue a downstream read.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous, active-low reset
//   MEM_R_EN     pipeline load request
//   MEM_W_EN     pipeline store request
//   address      byte address of the request
//   wdata        store data
//   rdata        load result (0 when no load completes this cycle)
//   ready        request completes this cycle (pipeline freeze = ~ready)
//   mem_R_EN     downstream read request
//   mem_W_EN     downstream write request
//   mem_address  downstream address
//   mem_wdata    downstream write data
//   mem_rdata    downstream read data
//   mem_ready    downstream transfer completes this cycle
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        mem_R_EN,
    output logic        mem_W_EN,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    logic [31:0] entry_addr [DEPTH];
    logic [31:0] entry_data [DEPTH];

    // Age of each slot relative to the head: 0 = oldest. A slot holds a live
    // store only when its age is below the current count, so no separate
    // valid bits are needed (reset just clears count).
    logic [PTR_W-1:0] entry_age [DEPTH];
    logic [DEPTH-1:0] entry_match;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign entry_age[gi]   = PTR_W'(gi) - rd_ptr_reg;
            assign entry_match[gi] = ({1'b0, entry_age[gi]} < count_reg) &&
                                     (entry_addr[gi][31:2] == address[31:2]);
        end
    endgenerate

    // Youngest matching entry wins so a load sees the most recent store.
    logic             hit;
    logic [PTR_W-1:0] hit_age;
    logic [31:0]      hit_data;

    always_comb begin
        hit      = 1'b0;
        hit_age  = '0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_match[i] && (!hit || entry_age[i] > hit_age)) begin
                hit      = 1'b1;
                hit_age  = entry_age[i];
                hit_data = entry_data[i];
            end
        end
    end

    // A store takes priority if both request lines are ever raised together.
    logic store_req;
    logic load_req;
    logic push;
    logic pop;
    logic load_hit;
    logic load_miss;
    logic load_done;

    assign store_req = MEM_W_EN;
    assign load_req  = MEM_R_EN & ~MEM_W_EN;
    // Push is decided on the pre-pop count: a full buffer never accepts in
    // the cycle it pops, the store lands one cycle later.
    assign push      = store_req & (count_reg != FULL);
    assign pop       = (state_reg == DRAIN) & mem_ready;
    assign load_hit  = load_req & hit;
    assign load_miss = load_req & ~hit;
    assign load_done = load_req & ~hit & (state_reg == LOAD) & mem_ready;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        ready = 1'b1;
        if (store_req) begin
            ready = (count_reg != FULL);
        end else if (load_req) begin
            ready = load_hit | load_done;
        end
    end

    always_comb begin
        rdata = '0;
        if (load_hit) begin
            rdata = hit_data;
        end else if (load_done) begin
            rdata = mem_rdata;
        end
    end

    // Downstream strobes come straight from the state register; the head
    // entry is stable during DRAIN because it only changes on a pop.
    assign mem_W_EN = (state_reg == DRAIN);
    assign mem_R_EN = (state_reg == LOAD);

    always_comb begin
        mem_address = '0;
        mem_wdata   = '0;
        if (state_reg == DRAIN) begin
            mem_address = entry_addr[rd_ptr_reg];
            mem_wdata   = entry_data[rd_ptr_reg];
        end else if (state_reg == LOAD) begin
            mem_address = address;
        end
    end

    // Entry storage carries no reset; liveness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_addr[wr_ptr_reg] <= address;
            entry_data[wr_ptr_reg] <= wdata;
        end
    end

    // Control: pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;

            case (state_reg)
                IDLE: begin
                    // Draining has priority over starting a load.
                    if (count_next != '0) begin
                        state_reg <= DRAIN;
                    end else if (load_miss) begin
                        state_reg <= LOAD;
                    end
                end
                DRAIN: begin
                    state_reg <= (count_next != '0) ? DRAIN : IDLE;
                end
                LOAD: begin
                    if (mem_ready) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//
// Directed bench for store_buffer (DEPTH = 4). A table of per-cycle vectors
// walks through posted stores, full-buffer stall, load hits (including the
// youngest-match and wrapped-slot cases), simultaneous push/pop and a
// drain-then-load miss. A hand-written sequence then resets the block in the
// middle of a drain and confirms the buffered stores are gone.
// -----------------------------------------------------------------------------
module tb_store_buffer;

    logic        clk;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        mem_R_EN;
    logic        mem_W_EN;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    store_buffer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (MEM_R_EN),
        .MEM_W_EN   (MEM_W_EN),
        .address    (address),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .mem_R_EN   (mem_R_EN),
        .mem_W_EN   (mem_W_EN),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r_en;
        logic        w_en;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] m_rdata;
        logic        m_ready;
        logic        e_ready;
        logic [31:0] e_rdata;
        logic        e_mr;
        logic        e_mw;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic r, input logic w,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] mrd, input logic mr,
                                input logic er, input logic [31:0] erd,
                                input logic emr, input logic emw,
                                input logic [31:0] ema, input logic [31:0] emd);
        vec_t v;
        v.r_en = r;  v.w_en = w;  v.addr = a;  v.wd = d;
        v.m_rdata = mrd;  v.m_ready = mr;
        v.e_ready = er;  v.e_rdata = erd;  v.e_mr = emr;  v.e_mw = emw;
        v.e_maddr = ema;  v.e_mwdata = emd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge and let them settle.
    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] mrd, input logic mr);
        @(negedge clk);
        MEM_R_EN  = r;
        MEM_W_EN  = w;
        address   = a;
        wdata     = d;
        mem_rdata = mrd;
        mem_ready = mr;
        #1;
    endtask

    initial begin
        // r w addr          wdata         mrdata  mrdy | ready rdata  mR mW maddr         mwdata
        vecs[0]  = mk(0,0,32'h0,    32'h0,         32'h0, 0, 1,32'h0,  0,0,32'h0,    32'h0);
        vecs[1]  = mk(0,1,32'h100,  32'hAAAA0001,  32'h0, 0, 1,32'h0,  0,0,32'h0,    32'h0);
        vecs[2]  = mk(0,0,32'h0,    32'h0,         32'h0, 0, 1,32'h0,  0,1,32'h100,  32'hAAAA0001);
        vecs[3]  = mk(0,1,32'h104,  32'h2,         32'h0, 0, 1,32'h0,  0,1,32'h100,  32'hAAAA0001);
        vecs[4]  = mk(0,1,32'h108,  32'h3,         32'h0, 0, 1,32'h0,  0,1,32'h100,  32'hAAAA0001);
        vecs[5]  = mk(0,1,32'h10C,  32'h4,         32'h0, 0, 1,32'h0,  0,1,32'h100,  32'hAAAA0001);
        vecs[6]  = mk(0,1,32'h110,  32'h5,         32'h0, 0, 0,32'h0,  0,1,32'h100,  32'hAAAA0001);
        vecs[7]  = mk(0,1,32'h110,  32'h5,         32'h0, 1, 0,32'h0,  0,1,32'h100,  32'hAAAA0001);
        vecs[8]  = mk(0,1,32'h110,  32'h5,         32'h0, 0, 1,32'h0,  0,1,32'h104,  32'h2);
        vecs[9]  = mk(1,0,32'h10A,  32'h0,         32'h0, 0, 1,32'h3,  0,1,32'h104,  32'h2);
        vecs[10] = mk(1,0,32'h112,  32'h0,         32'h0, 0, 1,32'h5,  0,1,32'h104,  32'h2);
        vecs[11] = mk(0,0,32'h0,    32'h0,         32'h0, 1, 1,32'h0,  0,1,32'h104,  32'h2);
        vecs[12] = mk(0,0,32'h0,    32'h0,         32'h0, 1, 1,32'h0,  0,1,32'h108,  32'h3);
        vecs[13] = mk(0,1,32'h200,  32'h11,        32'h0, 1, 1,32'h0,  0,1,32'h10C,  32'h4);
        vecs[14] = mk(0,1,32'h200,  32'h22,        32'h0, 0, 1,32'h0,  0,1,32'h110,  32'h5);
        vecs[15] = mk(1,0,32'h202,  32'h0,         32'h0, 0, 1,32'h22, 0,1,32'h110,  32'h5);
        vecs[16] = mk(0,0,32'h0,    32'h0,         32'h0, 1, 1,32'h0,  0,1,32'h110,  32'h5);
        vecs[17] = mk(0,0,32'h0,    32'h0,         32'h0, 1, 1,32'h0,  0,1,32'h200,  32'h11);
        vecs[18] = mk(0,0,32'h0,    32'h0,         32'h0, 1, 1,32'h0,  0,1,32'h200,  32'h22);
        vecs[19] = mk(0,0,32'h0,    32'h0,         32'h0, 0, 1,32'h0,  0,0,32'h0,    32'h0);
        vecs[20] = mk(0,1,32'h300,  32'h33,        32'h0, 0, 1,32'h0,  0,0,32'h0,    32'h0);
        vecs[21] = mk(1,0,32'h400,  32'h0,        32'h5A, 0, 0,32'h0,  0,1,32'h300,  32'h33);
        vecs[22] = mk(1,0,32'h400,  32'h0,        32'h5A, 1, 0,32'h0,  0,1,32'h300,  32'h33);
        vecs[23] = mk(1,0,32'h400,  32'h0,        32'h5A, 0, 0,32'h0,  0,0,32'h0,    32'h0);
        vecs[24] = mk(1,0,32'h400,  32'h0,        32'h5A, 0, 0,32'h0,  1,0,32'h400,  32'h0);
        vecs[25] = mk(1,0,32'h400,  32'h0,        32'h5A, 1, 1,32'h5A, 1,0,32'h400,  32'h0);
        vecs[26] = mk(0,0,32'h0,    32'h0,         32'h0, 0, 1,32'h0,  0,0,32'h0,    32'h0);

        rst = 1'b0;
        MEM_R_EN = 1'b0;  MEM_W_EN = 1'b0;
        address = '0;  wdata = '0;  mem_rdata = '0;  mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset ready",     {31'b0, ready},    32'h1);
        chk("reset rdata",     rdata,             32'h0);
        chk("reset mem_R_EN",  {31'b0, mem_R_EN}, 32'h0);
        chk("reset mem_W_EN",  {31'b0, mem_W_EN}, 32'h0);
        chk("reset mem_addr",  mem_address,       32'h0);
        chk("reset mem_wdata", mem_wdata,         32'h0);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].r_en, vecs[i].w_en, vecs[i].addr, vecs[i].wd,
                  vecs[i].m_rdata, vecs[i].m_ready);
            chk($sformatf("v%0d ready", i),    {31'b0, ready},    {31'b0, vecs[i].e_ready});
            chk($sformatf("v%0d rdata", i),    rdata,             vecs[i].e_rdata);
            chk($sformatf("v%0d mem_R_EN", i), {31'b0, mem_R_EN}, {31'b0, vecs[i].e_mr});
            chk($sformatf("v%0d mem_W_EN", i), {31'b0, mem_W_EN}, {31'b0, vecs[i].e_mw});
            chk($sformatf("v%0d mem_addr", i), mem_address,       vecs[i].e_maddr);
            chk($sformatf("v%0d mem_wdata", i), mem_wdata,        vecs[i].e_mwdata);
            $display("vec %0d: r=%0b w=%0b addr=0x%08h -> ready=%0b rdata=0x%08h mR=%0b mW=%0b maddr=0x%08h",
                     i, vecs[i].r_en, vecs[i].w_en, vecs[i].addr, ready, rdata,
                     mem_R_EN, mem_W_EN, mem_address);
        end

        // Build up three buffered stores with the pointers away from zero,
        // then reset in the middle of the drain.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 32'h700 + 32'(4 * i), 32'(i + 1), 32'h0, 0);
            chk($sformatf("pre-reset store %0d ready", i), {31'b0, ready}, 32'h1);
        end
        drive(0, 0, 32'h0, 32'h0, 32'h0, 1);
        chk("pre-reset head0", mem_address, 32'h700);
        drive(0, 0, 32'h0, 32'h0, 32'h0, 1);
        chk("pre-reset head1", mem_address, 32'h704);
        drive(0, 1, 32'h710, 32'h5, 32'h0, 0);
        chk("pre-reset store 4 ready", {31'b0, ready}, 32'h1);
        drive(0, 0, 32'h0, 32'h0, 32'h0, 0);
        chk("mid-drain mem_W_EN", {31'b0, mem_W_EN}, 32'h1);
        chk("mid-drain head", mem_address, 32'h708);
        $display("reset asserted mid-drain with three stores buffered");

        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post-reset mem_W_EN", {31'b0, mem_W_EN}, 32'h0);
        chk("post-reset mem_R_EN", {31'b0, mem_R_EN}, 32'h0);
        chk("post-reset ready",    {31'b0, ready},    32'h1);
        chk("post-reset mem_addr", mem_address,       32'h0);
        $display("post-reset: ready=%0b mW=%0b maddr=0x%08h", ready, mem_W_EN, mem_address);

        // Only a cleared buffer takes four new stores before stalling, and
        // the first of them must be the head.
        drive(0, 1, 32'h600, 32'h66, 32'h0, 0);
        chk("refill 0 ready", {31'b0, ready}, 32'h1);
        drive(0, 1, 32'h604, 32'h67, 32'h0, 0);
        chk("refill 1 ready", {31'b0, ready}, 32'h1);
        chk("refill head addr", mem_address, 32'h600);
        chk("refill head data", mem_wdata, 32'h66);
        drive(0, 1, 32'h608, 32'h68, 32'h0, 0);
        chk("refill 2 ready", {31'b0, ready}, 32'h1);
        drive(0, 1, 32'h60C, 32'h69, 32'h0, 0);
        chk("refill 3 ready", {31'b0, ready}, 32'h1);
        drive(0, 1, 32'h610, 32'h6A, 32'h0, 0);
        chk("refill 4 stall", {31'b0, ready}, 32'h0);
        $display("refill: fifth store ready=%0b", ready);

        drive(0, 0, 32'h0, 32'h0, 32'h0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of posted-store entries; power of two, minimum 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port MEM_R_EN  input  1  pipeline load request.
REQ-005 SHALL have port MEM_W_EN  input  1  pipeline store request.
REQ-006 SHALL have port address  input  32  byte address from the EXE stage register.
REQ-007 SHALL have port wdata  input  32  store data.
REQ-008 SHALL have port rdata  output  32  load result to the MEM stage register.
REQ-009 SHALL have port ready  output  1  request completes this cycle; pipeline freeze = ~ready.
REQ-010 SHALL have port mem_R_EN  output  1  read request to the downstream cache/SRAM path.
REQ-011 SHALL have port mem_W_EN  output  1  write request to the downstream path.
REQ-012 SHALL have port mem_address  output  32  downstream address.
REQ-013 SHALL have port mem_wdata  output  32  downstream write data.
REQ-014 SHALL have port mem_rdata  input  32  downstream read data.
REQ-015 SHALL have port mem_ready  input  1  downstream transfer completes this cycle.

Function
REQ-016 SHALL hold a circular FIFO of DEPTH {address, data} entries with write pointer, read pointer (log2 DEPTH bits, wrap DEPTH-1 -> 0) and count (0..DEPTH).
REQ-017 SHALL drive ready=1 with neither MEM_R_EN nor MEM_W_EN asserted.
REQ-018 Store: ready = (count < DEPTH), combinational; entry pushed at the edge where MEM_W_EN & ready.
REQ-019 Store while count == DEPTH: ready=0 until a pop; no push in the popping cycle (no full-pop bypass); push one cycle later.
REQ-020 Load hit: address[31:2] equals a valid entry's address[31:2] -> ready=1 same cycle, rdata = data of the youngest matching entry.
REQ-021 Load miss, count > 0: ready=0; FIFO drains; no downstream read until count == 0.
REQ-022 Load miss, count == 0: FSM enters LOAD; ready = mem_ready, rdata = mem_rdata combinationally while in LOAD.
REQ-023 FSM states: IDLE, DRAIN, LOAD.
REQ-024 IDLE -> DRAIN when count > 0; IDLE -> LOAD when load miss with count == 0; DRAIN has priority.
REQ-025 DRAIN: mem_W_EN=1, mem_address/mem_wdata = head entry, held stable until mem_ready=1; pop at that edge; -> DRAIN if count after pop > 0 or a push occurs that edge, else IDLE.
REQ-026 LOAD: mem_R_EN=1, mem_address = address; -> IDLE at the edge where mem_ready=1.
REQ-027 mem_R_EN and mem_W_EN SHALL never be asserted together.
REQ-028 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-029 rdata SHALL be 0 when no load completes this cycle.
REQ-030 Pipeline holds MEM_R_EN/MEM_W_EN/address/wdata stable while ready=0; the block relies on this.
REQ-031 Store hit on an existing entry SHALL still allocate a new entry (no merging); ordering preserved.

Reset
REQ-032 rst=0 at a rising edge: state=IDLE, pointers=0, count=0, all entries invalid.
REQ-033 After reset edge: mem_R_EN=0, mem_W_EN=0, mem_address=0, mem_wdata=0, rdata=0, ready=1 with no request.
REQ-034 Reset during DRAIN or LOAD SHALL abandon the transfer; buffered stores are lost.

Verification
REQ-035 Store 0x100<-0xAAAA0001, mem_ready held 0 -> ready=1, count=1, mem_W_EN=1, mem_address=0x100, mem_wdata=0xAAAA0001 from next cycle.
REQ-036 Five stores, mem_ready=0, DEPTH=4 -> first four ready=1, fifth ready=0; mem_ready pulse -> pop; fifth accepted next cycle.
REQ-037 Stores 0x200<-0x11, 0x200<-0x22, then load 0x202 -> ready=1 same cycle, rdata=0x22.
REQ-038 One store to 0x300 buffered, load 0x400 -> ready=0, write drains first; then mem_R_EN=1, mem_address=0x400; mem_ready=1 with mem_rdata=0x5A -> ready=1, rdata=0x5A.
REQ-039 Push and pop in the same cycle at count=2 -> count stays 2; pointer wrap 3->0 checked across 6 stores.
REQ-040 rst=0 mid-DRAIN with count=3 -> next cycle mem_W_EN=0, count=0, ready=1.
